// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// N+1 cycles accept-to-result (N = 32 for W ops, else XLEN); divide-by-zero/overflow answer in 1 cycle.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter bit HAS_W = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int CW   = $clog2(XLEN) + 1;
  localparam int XW2  = 2 * XLEN;
  localparam bit W_OK = HAS_W && (XLEN == 64);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            w_q, neg_q, out_valid_q;
  logic [XLEN-1:0] opa_q, result_q;
  logic [XW2-1:0]  opb_q, acc_q;

  logic            w_eff, a_sop, b_sop, a_neg, b_neg, b_zero, ovf, fast;
  logic [2:0]      op_eff;
  logic [XLEN-1:0] a_x, b_x, a_mag, b_mag, a_min, a_res, fast_res;
  logic [CW-1:0]   n_eff;

  always_comb begin
    w_eff  = word && W_OK;
    // W variants of MULH* collapse to MULW
    op_eff = (w_eff && !op[2]) ? 3'd0 : op;
    a_sop  = (op_eff == 3'd1) || (op_eff == 3'd2) || (op_eff == 3'd4) || (op_eff == 3'd6);
    b_sop  = (op_eff == 3'd1) || (op_eff == 3'd4) || (op_eff == 3'd6);
    if (w_eff) begin
      a_x   = a_sop ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0]);
      b_x   = b_sop ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0]);
      a_min = XLEN'($signed(32'h8000_0000));
      a_res = XLEN'($signed(a[31:0]));
      n_eff = CW'(32);
    end else begin
      a_x   = a;
      b_x   = b;
      a_min = {1'b1, {(XLEN-1){1'b0}}};
      a_res = a;
      n_eff = CW'(XLEN);
    end
    a_neg  = a_sop && a_x[XLEN-1];
    b_neg  = b_sop && b_x[XLEN-1];
    a_mag  = a_neg ? -a_x : a_x;
    b_mag  = b_neg ? -b_x : b_x;
    b_zero = (b_x == '0);
    ovf    = ((op_eff == 3'd4) || (op_eff == 3'd6)) && (a_x == a_min) && (b_x == '1);
    fast   = op_eff[2] && (b_zero || ovf);
    if (op_eff[1]) fast_res = b_zero ? a_res : '0;
    else           fast_res = b_zero ? '1 : a_res;
  end

  logic [XW2-1:0]  acc_n, opb_n, prod;
  logic [XLEN-1:0] opa_n, raw, fin;
  logic [XLEN:0]   rtry;
  logic            ge;

  // Next iteration step; the final step feeds the result directly so DONE lands on edge t+N
  always_comb begin
    rtry = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    ge   = (rtry >= {1'b0, opb_q[XLEN-1:0]});
    if (op_q[2]) begin
      opb_n = opb_q;
      opa_n = {opa_q[XLEN-2:0], ge};
      acc_n = ge ? XW2'(rtry[XLEN-1:0] - opb_q[XLEN-1:0]) : XW2'(rtry[XLEN-1:0]);
    end else begin
      acc_n = opa_q[0] ? (acc_q + opb_q) : acc_q;
      opb_n = opb_q << 1;
      opa_n = opa_q >> 1;
    end
    prod = neg_q ? -acc_n : acc_n;
    if (op_q[2]) begin
      raw = op_q[1] ? acc_n[XLEN-1:0] : opa_n;
      if (neg_q) raw = -raw;
    end else begin
      raw = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[XW2-1:XLEN];
    end
    fin = w_q ? XLEN'($signed(raw[31:0])) : raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      w_q         <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q  <= op_eff;
          w_q   <= w_eff;
          neg_q <= (op_eff == 3'd6) ? a_neg : (a_neg ^ b_neg);
          if (fast) begin
            state_q     <= DONE;
            result_q    <= fast_res;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= BUSY;
            cnt_q   <= n_eff;
            acc_q   <= '0;
            if (op_eff[2]) begin
              // dividend is left-aligned so its MSB always enters the remainder first
              opa_q <= w_eff ? (a_mag << 32) : a_mag;
              opb_q <= XW2'(b_mag);
            end else begin
              opa_q <= b_mag;
              opb_q <= XW2'(a_mag);
            end
          end
        end
        BUSY: begin
          acc_q <= acc_n;
          opa_q <= opa_n;
          opb_q <= opb_n;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            result_q    <= fin;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=64, HAS_W=1) with hand-computed expected results.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, word, out_valid, out_ready;
  logic [2:0]  op;
  logic [63:0] a, b, result;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64), .HAS_W(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  // Issues one request with out_ready held high; cyc counts cycles from accept to out_valid.
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] r, output int cyc, output int busy_bad);
    @(negedge clk);
    op = o; word = w; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1; busy_bad = 0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) busy_bad++;
      @(posedge clk); #1;
      cyc++;
    end
    r = result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; word = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h exp 0", result); end
    @(negedge clk); reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_mul();
    logic [63:0] r; int cyc, bb;
    run_op(3'd0, 1'b0, 64'd7, -64'sd3, r, cyc, bb);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_7x-3: got %h exp ffffffffffffffeb", r); end
    checks++; if (cyc !== 65) begin errors++; $display("FAIL mul_latency: got %0d exp 65", cyc); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL mul_busy_in_ready: got %0d cycles high exp 0", bb); end
  endtask

  task automatic test_mulh();
    logic [63:0] r; int cyc, bb;
    run_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, r, cyc, bb);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulh: got %h exp ffffffffffffffff", r); end
    run_op(3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd2, r, cyc, bb);
    checks++; if (r !== 64'h1) begin errors++; $display("FAIL mulhu: got %h exp 1", r); end
    run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, cyc, bb);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulhsu: got %h exp ffffffffffffffff", r); end
  endtask

  task automatic test_div();
    logic [63:0] r; int cyc, bb;
    run_op(3'd4, 1'b0, -64'sd7, 64'd2, r, cyc, bb);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_-7/2: got %h exp fffffffffffffffd", r); end
    run_op(3'd6, 1'b0, -64'sd7, 64'd2, r, cyc, bb);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_-7%%2: got %h exp ffffffffffffffff", r); end
    run_op(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, r, cyc, bb);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL divw: got %h exp fffffffffffffffd", r); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL divw_latency: got %0d exp 33", cyc); end
    run_op(3'd7, 1'b1, 64'h0000_0001_0000_0007, 64'd2, r, cyc, bb);
    checks++; if (r !== 64'h1) begin errors++; $display("FAIL remuw: got %h exp 1", r); end
    run_op(3'd5, 1'b0, 64'd100, 64'd7, r, cyc, bb);
    checks++; if (r !== 64'd14) begin errors++; $display("FAIL divu_100/7: got %h exp e", r); end
  endtask

  task automatic test_fast_path();
    logic [63:0] r; int cyc, bb;
    run_op(3'd5, 1'b0, 64'd5, 64'd0, r, cyc, bb);
    checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu_by0: got %h exp ffffffffffffffff", r); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL divu_by0_latency: got %0d exp 1", cyc); end
    run_op(3'd6, 1'b0, 64'd5, 64'd0, r, cyc, bb);
    checks++; if (r !== 64'd5) begin errors++; $display("FAIL rem_by0: got %h exp 5", r); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL rem_by0_latency: got %0d exp 1", cyc); end
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, cyc, bb);
    checks++; if (r !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL div_ovf: got %h exp 8000000000000000", r); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL div_ovf_latency: got %0d exp 1", cyc); end
    run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, cyc, bb);
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL rem_ovf: got %h exp 0", r); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL rem_ovf_latency: got %0d exp 1", cyc); end
  endtask

  task automatic test_backpressure();
    int cyc;
    @(negedge clk);
    op = 3'd0; word = 1'b0; a = 64'd3; b = 64'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== 65) begin errors++; $display("FAIL bp_latency: got %0d exp 65", cyc); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 64'd15 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b res=%h rdy=%b exp vld=1 res=f rdy=0", i, out_valid, result, in_ready);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    int pulses;
    @(negedge clk);
    op = 3'd5; word = 1'b0; a = 64'd1000; b = 64'd7; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_busy: got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    pulses = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (out_valid) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_result: got %0d valid cycles exp 0", pulses); end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 64'd2; b = 64'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_reject: got rdy=%b exp 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; int cyc, bb, pulses;
    @(negedge clk);
    op = 3'd4; word = 1'b0; a = 64'd99; b = 64'd4; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'h0) begin
      errors++; $display("FAIL reset_mid: got rdy=%b vld=%b res=%h exp rdy=1 vld=0 res=0", in_ready, out_valid, result);
    end
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (out_valid) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid_no_result: got %0d valid cycles exp 0", pulses); end
    run_op(3'd0, 1'b0, 64'd3, 64'd4, r, cyc, bb);
    checks++; if (r !== 64'd12) begin errors++; $display("FAIL mul_after_reset: got %h exp c", r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast_path();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
